// File: rtl/pcie_tx_arb.sv
// pcie_tx_arb: packet-granular round-robin merge of NUM_SRC AXI-S TLP streams
// into the single PCIe TX stream. A packet, once started, owns the output
// until its tlast beat is accepted.
// Optional build macro PCIE_TX_ARB_OUTREG_EN: registers the mst side through a
// 2-entry skid buffer (+1 cycle latency, full throughput). Without it the
// src->mst path is purely combinational.
module pcie_tx_arb #(
   parameter int NUM_SRC = 3,
   parameter int DATA_W  = 512,
   parameter int USER_W  = 10
) (
   input  logic                           fim_clk,
   input  logic                           fim_rst_n,
   input  logic [NUM_SRC-1:0]             src_en,
   input  logic [NUM_SRC-1:0]             src_tvalid,
   output logic [NUM_SRC-1:0]             src_tready,
   input  logic [NUM_SRC*DATA_W-1:0]      src_tdata,
   input  logic [NUM_SRC*DATA_W/8-1:0]    src_tkeep,
   input  logic [NUM_SRC-1:0]             src_tlast,
   input  logic [NUM_SRC*USER_W-1:0]      src_tuser_vendor,
   output logic                           mst_tvalid,
   output logic [DATA_W-1:0]              mst_tdata,
   output logic [DATA_W/8-1:0]            mst_tkeep,
   output logic                           mst_tlast,
   output logic [USER_W-1:0]              mst_tuser_vendor,
   input  logic                           mst_tready,
   output logic [$clog2(NUM_SRC)-1:0]     gnt_id,
   output logic                           busy,
   output logic [31:0]                    pkt_cnt
);

   localparam int IDX_W  = $clog2(NUM_SRC);
   localparam int KEEP_W = DATA_W / 8;

   typedef enum logic {IDLE, LOCK} state_e;

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]    gnt_q, gnt_d;
   logic [31:0]         pkt_cnt_q, pkt_cnt_d;
   logic [NUM_SRC-1:0]  eligible;
   logic                any_elig;
   logic [IDX_W-1:0]    pick, sel, sel_inc;
   logic                pick_found;
   logic                in_valid, in_ready, in_fire, in_last;
   logic [DATA_W-1:0]   in_data;
   logic [KEEP_W-1:0]   in_keep;
   logic [USER_W-1:0]   in_user;

   // Qualifying with reset keeps mst_tvalid/src_tready low while reset is held,
   // even if upstream still drives tvalid.
   assign eligible = src_tvalid & src_en & {NUM_SRC{fim_rst_n}};
   assign any_elig = |eligible;

   // Round-robin pick: first eligible index scanning upward from rr_ptr_q.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      pick       = '0;
      pick_found = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         int idx;
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_SRC) idx = idx - NUM_SRC;
         if (!pick_found && eligible[idx]) begin
            pick_found = 1'b1;
            pick       = IDX_W'(idx);
         end
      end
   end

   // gnt_q tracks the pick while idle, so it also serves as the "last grant" that gnt_id holds.
   assign sel     = (state_q == LOCK || !any_elig) ? gnt_q : pick;
   assign sel_inc = (sel == IDX_W'(NUM_SRC - 1)) ? '0 : sel + 1'b1;

   // Mid-packet the granted source keeps the output even if its enable drops.
   assign in_valid = (state_q == LOCK) ? src_tvalid[sel] : any_elig;
   assign in_data  = src_tdata[int'(sel)*DATA_W +: DATA_W];
   assign in_keep  = src_tkeep[int'(sel)*KEEP_W +: KEEP_W];
   assign in_user  = src_tuser_vendor[int'(sel)*USER_W +: USER_W];
   assign in_last  = src_tlast[sel];
   assign in_fire  = in_valid && in_ready;

   // Ready is returned only to the selected source.
   always_comb begin
      src_tready = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (IDX_W'(i) == sel)
            src_tready[i] = in_ready && fim_rst_n && (state_q == LOCK || eligible[i]);
      end
   end

   // Next-state: packet lock, round-robin pointer advance and packet counting.
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      gnt_d     = gnt_q;
      pkt_cnt_d = pkt_cnt_q;
      case (state_q)
         IDLE: begin
            if (any_elig) begin
               gnt_d = pick;
               if (in_fire && in_last) rr_ptr_d = sel_inc;
               else                    state_d  = LOCK;
            end
         end
         LOCK: begin
            if (in_fire && in_last) begin
               state_d  = IDLE;
               rr_ptr_d = sel_inc;
            end
         end
         default: state_d = IDLE;
      endcase
      if (in_fire && in_last) pkt_cnt_d = pkt_cnt_q + 32'd1;
   end

   // Arbiter state registers.
   always_ff @(posedge fim_clk or negedge fim_rst_n) begin
      if (!fim_rst_n) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         gnt_q     <= '0;
         pkt_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         gnt_q     <= gnt_d;
         pkt_cnt_q <= pkt_cnt_d;
      end
   end

   assign gnt_id  = sel;
   assign busy    = (state_q == LOCK);
   assign pkt_cnt = pkt_cnt_q;

`ifdef PCIE_TX_ARB_OUTREG_EN
   localparam int PAY_W = DATA_W + KEEP_W + 1 + USER_W;

   logic             out_valid_q, skid_valid_q;
   logic [PAY_W-1:0] out_pay_q, skid_pay_q, in_pay;

   assign in_pay   = {in_data, in_keep, in_last, in_user};
   assign in_ready = !skid_valid_q;

   // Skid valids: the output slot refills from skid first; skid catches a beat during a stall.
   always_ff @(posedge fim_clk or negedge fim_rst_n) begin
      if (!fim_rst_n) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
      end else if (!out_valid_q || mst_tready) begin
         if (skid_valid_q) begin
            out_valid_q  <= 1'b1;
            skid_valid_q <= 1'b0;
         end else begin
            out_valid_q  <= in_fire;
         end
      end else if (in_fire) begin
         skid_valid_q <= 1'b1;
      end
   end

   // Skid payload moves alongside the valids above.
   always_ff @(posedge fim_clk) begin
      // NOTE: payload flops carry no reset; the valid bits alone say whether they hold data.
      if (!out_valid_q || mst_tready) out_pay_q  <= skid_valid_q ? skid_pay_q : in_pay;
      else if (in_fire)               skid_pay_q <= in_pay;
   end

   assign mst_tvalid = out_valid_q;
   assign {mst_tdata, mst_tkeep, mst_tlast, mst_tuser_vendor} = out_pay_q;
`else
   assign in_ready         = mst_tready;
   assign mst_tvalid       = in_valid;
   assign mst_tdata        = in_data;
   assign mst_tkeep        = in_keep;
   assign mst_tlast        = in_last;
   assign mst_tuser_vendor = in_user;
`endif

endmodule

// File: tb/tb_pcie_tx_arb.sv
// tb_pcie_tx_arb: directed scenarios for the pass-through build of pcie_tx_arb
// (3 sources, 32-bit data). Inputs change 1 time unit after the rising edge;
// outputs are compared 1 time unit later, well clear of the next edge.
module tb_pcie_tx_arb;

   localparam int NS = 3;
   localparam int DW = 32;
   localparam int UW = 10;

   logic              fim_clk = 1'b0;
   logic              fim_rst_n = 1'b1;
   logic [NS-1:0]     src_en = '0;
   logic [NS-1:0]     src_tvalid = '0;
   logic [NS-1:0]     src_tlast = '0;
   logic [NS-1:0]     src_tready;
   logic [NS*DW-1:0]  src_tdata;
   logic [NS*DW/8-1:0] src_tkeep;
   logic [NS*UW-1:0]  src_tuser_vendor;
   logic              mst_tvalid, mst_tlast;
   logic [DW-1:0]     mst_tdata;
   logic [DW/8-1:0]   mst_tkeep;
   logic [UW-1:0]     mst_tuser_vendor;
   logic              mst_tready = 1'b0;
   logic [1:0]        gnt_id;
   logic              busy;
   logic [31:0]       pkt_cnt;
   logic [DW-1:0]     dat [NS];

   int errors = 0;
   int checks = 0;

   always #5 fim_clk = ~fim_clk;

   // Per-source payload: data from dat[], all bytes kept, tuser = source index.
   always_comb begin
      for (int i = 0; i < NS; i++) begin
         src_tdata[i*DW +: DW]       = dat[i];
         src_tkeep[i*DW/8 +: DW/8]   = '1;
         src_tuser_vendor[i*UW +: UW] = UW'(i);
      end
   end

   pcie_tx_arb #(.NUM_SRC(NS), .DATA_W(DW), .USER_W(UW)) dut (
      .fim_clk          (fim_clk),
      .fim_rst_n        (fim_rst_n),
      .src_en           (src_en),
      .src_tvalid       (src_tvalid),
      .src_tready       (src_tready),
      .src_tdata        (src_tdata),
      .src_tkeep        (src_tkeep),
      .src_tlast        (src_tlast),
      .src_tuser_vendor (src_tuser_vendor),
      .mst_tvalid       (mst_tvalid),
      .mst_tdata        (mst_tdata),
      .mst_tkeep        (mst_tkeep),
      .mst_tlast        (mst_tlast),
      .mst_tuser_vendor (mst_tuser_vendor),
      .mst_tready       (mst_tready),
      .gnt_id           (gnt_id),
      .busy             (busy),
      .pkt_cnt          (pkt_cnt)
   );

   function automatic logic [DW-1:0] mk(input int s, input int b);
      return {16'hC0DE, 8'(s), 8'(b)};
   endfunction

   task automatic next_cycle();
      @(posedge fim_clk);
      #1;
   endtask

   task automatic apply_reset();
      src_tvalid = '0;
      src_tlast  = '0;
      fim_rst_n  = 1'b0;
      #2;
      fim_rst_n  = 1'b1;
      next_cycle();
   endtask

   task automatic test_reset();
      mst_tready = 1'b1;
      #1 fim_rst_n = 1'b0;
      #1;
      checks++; if (mst_tvalid !== 1'b0) begin errors++; $display("FAIL reset_mst_tvalid: got %0b want 0", mst_tvalid); end
      checks++; if (src_tready !== 3'b000) begin errors++; $display("FAIL reset_src_tready: got %b want 000", src_tready); end
      checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL reset_gnt_id: got %0d want 0", gnt_id); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
      checks++; if (pkt_cnt !== 32'd0) begin errors++; $display("FAIL reset_pkt_cnt: got %0d want 0", pkt_cnt); end
      next_cycle();
      fim_rst_n = 1'b1;
      next_cycle();
      checks++; if (busy !== 1'b0 || mst_tvalid !== 1'b0) begin errors++; $display("FAIL reset_release: busy=%0b tvalid=%0b want 0/0", busy, mst_tvalid); end
   endtask

   task automatic test_single();
      logic exp_last;
      apply_reset();
      src_en = 3'b111;
      mst_tready = 1'b1;
      for (int b = 0; b < 4; b++) begin
         src_tvalid = 3'b001;
         dat[0]     = mk(0, b);
         exp_last   = (b == 3);
         src_tlast  = {2'b00, exp_last};
         #1;
         checks++; if (mst_tvalid !== 1'b1) begin errors++; $display("FAIL single_valid b%0d: got %0b want 1", b, mst_tvalid); end
         checks++; if (mst_tdata !== mk(0, b)) begin errors++; $display("FAIL single_data b%0d: got %h want %h", b, mst_tdata, mk(0, b)); end
         checks++; if (mst_tlast !== exp_last) begin errors++; $display("FAIL single_last b%0d: got %0b want %0b", b, mst_tlast, exp_last); end
         checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL single_gnt b%0d: got %0d want 0", b, gnt_id); end
         checks++; if (src_tready !== 3'b001) begin errors++; $display("FAIL single_ready b%0d: got %b want 001", b, src_tready); end
         checks++; if (busy !== (b != 0)) begin errors++; $display("FAIL single_busy b%0d: got %0b want %0b", b, busy, (b != 0)); end
         if (b == 0) begin
            checks++; if (mst_tkeep !== 4'hF || mst_tuser_vendor !== 10'd0) begin errors++; $display("FAIL single_sideband: keep=%h user=%0d want F/0", mst_tkeep, mst_tuser_vendor); end
         end
         next_cycle();
      end
      src_tvalid = '0;
      src_tlast  = '0;
      #1;
      checks++; if (pkt_cnt !== 32'd1) begin errors++; $display("FAIL single_pkt_cnt: got %0d want 1", pkt_cnt); end
      checks++; if (busy !== 1'b0 || mst_tvalid !== 1'b0) begin errors++; $display("FAIL single_after: busy=%0b tvalid=%0b want 0/0", busy, mst_tvalid); end
   endtask

   task automatic test_fairness();
      logic [1:0] exp;
      apply_reset();
      src_en     = 3'b111;
      mst_tready = 1'b1;
      src_tvalid = 3'b111;
      src_tlast  = 3'b111;
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < NS; i++) dat[i] = mk(i, k);
         exp = 2'(k % 3);
         #1;
         checks++; if (gnt_id !== exp) begin errors++; $display("FAIL fair_gnt c%0d: got %0d want %0d", k, gnt_id, exp); end
         checks++; if (mst_tdata !== mk(int'(exp), k)) begin errors++; $display("FAIL fair_data c%0d: got %h want %h", k, mst_tdata, mk(int'(exp), k)); end
         checks++; if (src_tready !== (3'b001 << exp)) begin errors++; $display("FAIL fair_ready c%0d: got %b want %b", k, src_tready, 3'b001 << exp); end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fair_busy c%0d: got %0b want 0", k, busy); end
         next_cycle();
      end
      src_tvalid = '0;
      #1;
      checks++; if (pkt_cnt !== 32'd6) begin errors++; $display("FAIL fair_pkt_cnt: got %0d want 6", pkt_cnt); end
   endtask

   task automatic test_stall();
      apply_reset();
      src_en     = 3'b111;
      mst_tready = 1'b0;
      src_tvalid = 3'b010;
      src_tlast  = 3'b000;
      dat[0] = mk(0, 9);
      dat[1] = mk(1, 0);
      dat[2] = mk(2, 9);
      for (int c = 0; c < 5; c++) begin
         if (c == 1) begin
            src_tvalid = 3'b111;
            src_tlast  = 3'b101;
         end
         #1;
         checks++; if (mst_tvalid !== 1'b1 || mst_tdata !== mk(1, 0)) begin errors++; $display("FAIL stall_data c%0d: valid=%0b data=%h want 1/%h", c, mst_tvalid, mst_tdata, mk(1, 0)); end
         checks++; if (gnt_id !== 2'd1) begin errors++; $display("FAIL stall_gnt c%0d: got %0d want 1", c, gnt_id); end
         checks++; if (src_tready !== 3'b000) begin errors++; $display("FAIL stall_ready c%0d: got %b want 000", c, src_tready); end
         checks++; if (busy !== (c != 0)) begin errors++; $display("FAIL stall_busy c%0d: got %0b want %0b", c, busy, (c != 0)); end
         next_cycle();
      end
      mst_tready = 1'b1;
      #1;
      checks++; if (src_tready !== 3'b010 || mst_tdata !== mk(1, 0)) begin errors++; $display("FAIL stall_release: ready=%b data=%h want 010/%h", src_tready, mst_tdata, mk(1, 0)); end
      next_cycle();
      dat[1]    = mk(1, 1);
      src_tlast = 3'b111;
      #1;
      checks++; if (gnt_id !== 2'd1 || mst_tdata !== mk(1, 1) || mst_tlast !== 1'b1) begin errors++; $display("FAIL stall_tail: gnt=%0d data=%h last=%0b want 1/%h/1", gnt_id, mst_tdata, mst_tlast, mk(1, 1)); end
      next_cycle();
      src_tvalid = 3'b101;
      #1;
      checks++; if (gnt_id !== 2'd2 || mst_tdata !== mk(2, 9)) begin errors++; $display("FAIL stall_next: gnt=%0d data=%h want 2/%h", gnt_id, mst_tdata, mk(2, 9)); end
      next_cycle();
      src_tvalid = '0;
   endtask

   task automatic test_enable();
      logic [1:0] exp;
      apply_reset();
      src_en     = 3'b101;
      mst_tready = 1'b1;
      src_tvalid = 3'b111;
      src_tlast  = 3'b111;
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < NS; i++) dat[i] = mk(i, k);
         exp = (k % 2 == 0) ? 2'd0 : 2'd2;
         #1;
         checks++; if (gnt_id !== exp || src_tready !== (3'b001 << exp)) begin errors++; $display("FAIL en_mask c%0d: gnt=%0d ready=%b want %0d/%b", k, gnt_id, src_tready, exp, 3'b001 << exp); end
         next_cycle();
      end
      src_tlast = 3'b001;
      dat[2]    = mk(2, 0);
      #1;
      checks++; if (gnt_id !== 2'd2 || busy !== 1'b0) begin errors++; $display("FAIL en_pkt_start: gnt=%0d busy=%0b want 2/0", gnt_id, busy); end
      next_cycle();
      src_en = 3'b001;
      dat[2] = mk(2, 1);
      #1;
      checks++; if (gnt_id !== 2'd2 || busy !== 1'b1) begin errors++; $display("FAIL en_drop_hold: gnt=%0d busy=%0b want 2/1", gnt_id, busy); end
      checks++; if (mst_tvalid !== 1'b1 || mst_tdata !== mk(2, 1) || src_tready !== 3'b100) begin errors++; $display("FAIL en_drop_beat: valid=%0b data=%h ready=%b want 1/%h/100", mst_tvalid, mst_tdata, src_tready, mk(2, 1)); end
      next_cycle();
      dat[2]    = mk(2, 2);
      src_tlast = 3'b101;
      #1;
      checks++; if (gnt_id !== 2'd2 || mst_tdata !== mk(2, 2) || mst_tlast !== 1'b1) begin errors++; $display("FAIL en_drop_tail: gnt=%0d data=%h last=%0b want 2/%h/1", gnt_id, mst_tdata, mst_tlast, mk(2, 2)); end
      next_cycle();
      for (int k = 0; k < 2; k++) begin
         dat[0] = mk(0, k);
         #1;
         checks++; if (gnt_id !== 2'd0 || src_tready !== 3'b001 || busy !== 1'b0) begin errors++; $display("FAIL en_only0 c%0d: gnt=%0d ready=%b busy=%0b want 0/001/0", k, gnt_id, src_tready, busy); end
         next_cycle();
      end
      src_tvalid = '0;
      src_en     = 3'b111;
   endtask

   task automatic test_wrap();
      apply_reset();
      src_en     = 3'b111;
      mst_tready = 1'b1;
      force dut.pkt_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.pkt_cnt_q;
      checks++; if (pkt_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload: got %h want ffffffff", pkt_cnt); end
      src_tvalid = 3'b001;
      src_tlast  = 3'b001;
      dat[0]     = mk(0, 0);
      next_cycle();
      src_tvalid = '0;
      #1;
      checks++; if (pkt_cnt !== 32'd0) begin errors++; $display("FAIL wrap_pkt_cnt: got %h want 0", pkt_cnt); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      src_en     = 3'b111;
      mst_tready = 1'b1;
      src_tvalid = 3'b010;
      src_tlast  = 3'b010;
      dat[1]     = mk(1, 0);
      #1;
      checks++; if (gnt_id !== 2'd1) begin errors++; $display("FAIL rmid_pre_gnt: got %0d want 1", gnt_id); end
      next_cycle();
      src_tvalid = 3'b001;
      src_tlast  = 3'b000;
      for (int b = 0; b < 2; b++) begin
         dat[0] = mk(0, b);
         next_cycle();
      end
      dat[0] = mk(0, 2);
      #1;
      checks++; if (busy !== 1'b1 || pkt_cnt !== 32'd1) begin errors++; $display("FAIL rmid_inflight: busy=%0b pkt_cnt=%0d want 1/1", busy, pkt_cnt); end
      fim_rst_n = 1'b0;
      #1;
      checks++; if (mst_tvalid !== 1'b0 || src_tready !== 3'b000) begin errors++; $display("FAIL rmid_async_hs: valid=%0b ready=%b want 0/000", mst_tvalid, src_tready); end
      checks++; if (busy !== 1'b0 || gnt_id !== 2'd0 || pkt_cnt !== 32'd0) begin errors++; $display("FAIL rmid_async_st: busy=%0b gnt=%0d pkt_cnt=%0d want 0/0/0", busy, gnt_id, pkt_cnt); end
      next_cycle();
      src_tvalid = '0;
      fim_rst_n  = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || gnt_id !== 2'd0 || mst_tvalid !== 1'b0) begin errors++; $display("FAIL rmid_release: busy=%0b gnt=%0d valid=%0b want 0/0/0", busy, gnt_id, mst_tvalid); end
      src_tvalid = 3'b111;
      src_tlast  = 3'b111;
      for (int i = 0; i < NS; i++) dat[i] = mk(i, 7);
      #1;
      checks++; if (gnt_id !== 2'd0 || mst_tdata !== mk(0, 7)) begin errors++; $display("FAIL rmid_next_gnt: gnt=%0d data=%h want 0/%h", gnt_id, mst_tdata, mk(0, 7)); end
      next_cycle();
      src_tvalid = '0;
   endtask

   initial begin
      for (int i = 0; i < NS; i++) dat[i] = '0;
      test_reset();
      test_single();
      test_fairness();
      test_stall();
      test_enable();
      test_wrap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
